// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache line-fill controller.
// Build option: define CACHE_FILL_RR_EN for round-robin miss arbitration.
package cache_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DRAIN
   } state_e;

   localparam int ADDR_W_DEF     = 16;
   localparam int DATA_W_DEF     = 16;
   localparam int LINE_WORDS_DEF = 8;
   localparam int MEM_LAT_DEF    = 4;
   localparam int NUM_REQ_DEF    = 2;

   localparam int OFF_W_DEF = $clog2(LINE_WORDS_DEF) + 1;
   localparam int CNT_W_DEF = $clog2(LINE_WORDS_DEF) + 1;

   function automatic int off_bits(input int line_words);
      return $clog2(line_words) + 1;
   endfunction

endpackage

// File: rtl/req_arbiter.sv
// One-hot miss arbiter: fixed lowest-index priority by default,
// round-robin from last owner + 1 when CACHE_FILL_RR_EN is defined.
module req_arbiter
   import cache_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
`ifdef CACHE_FILL_RR_EN
   input  logic               clk,
   input  logic               rst,
   input  logic               grant_en,
`endif
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               any
);

   assign any = |req;

`ifdef CACHE_FILL_RR_EN
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   // Search starts one past the last owner and wraps.
   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      for (int i = 1; i <= NUM_REQ; i++) begin
         int idx;
         idx = (int'(ptr_q) + i) % NUM_REQ;
         if (req[idx] && (grant == '0)) begin
            grant[idx] = 1'b1;
            ptr_d      = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (grant_en && any) begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign grant = req & (~req + NUM_REQ'(1));
`endif

endmodule

// File: rtl/cache_fill_ctrl.sv
// Multi-requester cache line-fill engine over a pipelined memory.
// Build option: CACHE_FILL_RR_EN selects round-robin arbitration.
module cache_fill_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int LINE_WORDS = LINE_WORDS_DEF,
   parameter int MEM_LAT    = MEM_LAT_DEF,
   parameter int NUM_REQ    = NUM_REQ_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        miss_req,
   input  logic [NUM_REQ*ADDR_W-1:0] miss_addr,
   output logic [NUM_REQ-1:0]        fsm_busy,
   output logic [NUM_REQ-1:0]        fill_we,
   output logic [NUM_REQ-1:0]        fill_tag_we,
   output logic [ADDR_W-1:0]         fill_addr,
   output logic [DATA_W-1:0]         fill_data,
   output logic                      mem_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [DATA_W-1:0]         mem_data_in,
   input  logic                      mem_data_valid
);

   localparam int OFF_W = off_bits(LINE_WORDS);
   localparam int CNT_W = off_bits(LINE_WORDS);

   localparam logic [CNT_W-1:0]  LAST = CNT_W'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0]  FULL = CNT_W'(LINE_WORDS);
   localparam logic [ADDR_W-1:0] MASK = {ADDR_W{1'b1}} << OFF_W;

   if ((MEM_LAT < 1) || (LINE_WORDS < 2) || (NUM_REQ < 1)) begin : g_bad_cfg
      $fatal(1, "cache_fill_ctrl: unsupported parameter set");
   end

   state_e               state_q;
   logic [NUM_REQ-1:0]   owner_q;
   logic [ADDR_W-1:0]    base_q;
   logic [CNT_W-1:0]     issue_q;
   logic [CNT_W-1:0]     rx_q;

   logic [NUM_REQ-1:0]   grant;
   logic                 any_req;
   logic [ADDR_W-1:0]    sel_addr;
   logic                 wr;
   logic                 last_rx;

   req_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
`ifdef CACHE_FILL_RR_EN
      .clk      (clk),
      .rst      (rst),
      .grant_en (state_q == S_IDLE),
`endif
      .req      (miss_req),
      .grant    (grant),
      .any      (any_req)
   );

   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr = miss_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Stale or surplus returns (IDLE, or past the line) never write.
   assign wr = mem_data_valid && (state_q != S_IDLE) && (rx_q < FULL);
   assign last_rx = wr && (rx_q == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         base_q  <= '0;
         issue_q <= '0;
         rx_q    <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  owner_q <= grant;
                  base_q  <= sel_addr & MASK;
                  issue_q <= '0;
                  rx_q    <= '0;
                  state_q <= S_FILL;
               end
            end
            S_FILL: begin
               issue_q <= issue_q + 1'b1;
               if (issue_q == LAST) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
            end
            default: state_q <= S_IDLE;
         endcase
         if (wr) begin
            rx_q <= rx_q + 1'b1;
         end
         if (last_rx) begin
            state_q <= S_IDLE;
         end
      end
   end

   assign mem_en      = (state_q == S_FILL);
   assign mem_addr    = mem_en ? base_q + ADDR_W'({issue_q, 1'b0}) : '0;
   assign fill_we     = wr ? owner_q : '0;
   assign fill_tag_we = last_rx ? owner_q : '0;
   assign fill_addr   = wr ? base_q + ADDR_W'({rx_q, 1'b0}) : '0;
   assign fill_data   = wr ? mem_data_in : '0;
   assign fsm_busy    = miss_req | ((state_q != S_IDLE) ? owner_q : '0);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: default geometry plus a
// LINE_WORDS=2 / MEM_LAT=1 instance.
module tb_cache_fill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  miss_req;
   logic [31:0] miss_addr;
   logic [1:0]  fsm_busy, fill_we, fill_tag_we;
   logic [15:0] fill_addr, fill_data, mem_addr, mem_data_in;
   logic        mem_en, mem_data_valid;
   logic        extra_v;

   logic [1:0]  miss2;
   logic [31:0] addr2;
   logic [1:0]  busy2, we2, tw2;
   logic [15:0] fa2, fd2, ma2, md2;
   logic        me2, mv2;

   int checks = 0;
   int errors = 0;

`ifdef CACHE_FILL_RR_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif

   always #5 clk = ~clk;

   cache_fill_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .miss_req       (miss_req),
      .miss_addr      (miss_addr),
      .fsm_busy       (fsm_busy),
      .fill_we        (fill_we),
      .fill_tag_we    (fill_tag_we),
      .fill_addr      (fill_addr),
      .fill_data      (fill_data),
      .mem_en         (mem_en),
      .mem_addr       (mem_addr),
      .mem_data_in    (mem_data_in),
      .mem_data_valid (mem_data_valid)
   );

   cache_fill_ctrl #(
      .LINE_WORDS (2),
      .MEM_LAT    (1)
   ) dut2 (
      .clk            (clk),
      .rst            (rst),
      .miss_req       (miss2),
      .miss_addr      (addr2),
      .fsm_busy       (busy2),
      .fill_we        (we2),
      .fill_tag_we    (tw2),
      .fill_addr      (fa2),
      .fill_data      (fd2),
      .mem_en         (me2),
      .mem_addr       (ma2),
      .mem_data_in    (md2),
      .mem_data_valid (mv2)
   );

   // Memory models: 4-cycle and 1-cycle pipelines, data tagged by word.
   logic [4:1]  vpipe = '0;
   logic [15:0] apipe [1:4];
   logic        v2 = 1'b0;
   logic [15:0] a2 = '0;

   always @(posedge clk) begin
      vpipe    <= {vpipe[3:1], mem_en};
      apipe[1] <= mem_addr;
      apipe[2] <= apipe[1];
      apipe[3] <= apipe[2];
      apipe[4] <= apipe[3];
      v2       <= me2;
      a2       <= ma2;
   end

   assign mem_data_valid = vpipe[4] | extra_v;
   assign mem_data_in    = 16'hA000 + {13'b0, apipe[4][3:1]};
   assign mv2            = v2;
   assign md2            = 16'hB000 + {15'b0, a2[1]};

   wire [63:0] obs1 = {9'b0, mem_en, mem_addr, fill_we, fill_tag_we,
                       fill_addr, fill_data, fsm_busy};
   wire [63:0] obs2 = {9'b0, me2, ma2, we2, tw2, fa2, fd2, busy2};

   function automatic logic [63:0] pk(
      input logic me, input logic [15:0] ma, input logic [1:0] we,
      input logic [1:0] tw, input logic [15:0] fa, input logic [15:0] fd,
      input logic [1:0] busy);
      return {9'b0, me, ma, we, tw, fa, fd, busy};
   endfunction

   // Expected outputs t cycles after a miss seen in IDLE (defaults).
   function automatic logic [63:0] expv(
      input int t, input int o, input logic [15:0] b, input logic [1:0] mr);
      logic [1:0]  oh;
      logic        me;
      logic        w;
      logic [15:0] k;
      oh = (o == 0) ? 2'b01 : 2'b10;
      me = (t >= 1) && (t <= 8);
      w  = (t >= 5) && (t <= 12);
      k  = 16'(t - 5);
      return pk(me,
                me ? b + 16'(2 * (t - 1)) : 16'h0,
                w ? oh : 2'b00,
                (t == 12) ? oh : 2'b00,
                w ? b + 16'(2 * k) : 16'h0,
                w ? 16'hA000 + k : 16'h0,
                mr | (((t >= 1) && (t <= 12)) ? oh : 2'b00));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int which, input logic [63:0] e);
      logic [63:0] o;
      #1;
      o = (which == 0) ? obs1 : obs2;
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic fill(input string tag, input int o, input logic [15:0] a,
                       input int drop_t, input int stop_t);
      logic [15:0] b;
      b = a & 16'hFFF0;
      for (int t = 0; t <= stop_t; t++) begin
         if (t > 0) tick();
         chk($sformatf("%s_t%0d", tag, t), 0, expv(t, o, b, miss_req));
         if (t == drop_t) miss_req[o] = 1'b0;
      end
   endtask

   initial begin
      rst       = 1'b1;
      miss_req  = 2'b10;
      miss_addr = '0;
      extra_v   = 1'b0;
      miss2     = '0;
      addr2     = '0;
      tick();
      chk("reset_outputs", 0, pk(0, 0, 0, 0, 0, 0, 2'b10));
      miss_req = 2'b00;
      tick();
      rst = 1'b0;
      chk("reset_idle", 0, pk(0, 0, 0, 0, 0, 0, 2'b00));

      // Single D-cache miss.
      tick();
      miss_req  = 2'b01;
      miss_addr = {16'h0, 16'h1234};
      fill("dmiss", 0, 16'h1234, 12, 13);

      // Two simultaneous pairs.
      tick();
      miss_req  = 2'b11;
      miss_addr = {16'h4010, 16'h2000};
      fill("pair1a", FIRST, (FIRST == 0) ? 16'h2000 : 16'h4010, 12, 13);
      fill("pair1b", 1 - FIRST, (FIRST == 0) ? 16'h4010 : 16'h2000, 12, 13);
      tick();
      miss_req  = 2'b11;
      miss_addr = {16'h5000, 16'h3000};
      fill("pair2a", FIRST, (FIRST == 0) ? 16'h3000 : 16'h5000, 12, 13);
      fill("pair2b", 1 - FIRST, (FIRST == 0) ? 16'h5000 : 16'h3000, 12, 13);

      // Requester drops its miss at T3; the fill completes.
      tick();
      miss_req  = 2'b01;
      miss_addr = {16'h0, 16'h1234};
      fill("drop", 0, 16'h1234, 3, 13);

      // Reset mid-fill, stale returns ignored, then a clean fill.
      tick();
      miss_req  = 2'b01;
      miss_addr = {16'h0, 16'h7008};
      fill("prerst", 0, 16'h7008, 99, 5);
      tick();
      rst      = 1'b1;
      miss_req = 2'b00;
      chk("rst_now", 0, pk(0, 0, 0, 0, 0, 0, 2'b00));
      tick();
      rst = 1'b0;
      chk("rst_t7", 0, pk(0, 0, 0, 0, 0, 0, 2'b00));
      for (int i = 8; i <= 12; i++) begin
         tick();
         chk($sformatf("rst_t%0d", i), 0, pk(0, 0, 0, 0, 0, 0, 2'b00));
      end
      miss_req  = 2'b01;
      miss_addr = {16'h0, 16'h6000};
      fill("afterrst", 0, 16'h6000, 12, 13);

      // Top-of-space line and a stray valid in IDLE.
      tick();
      miss_req  = 2'b01;
      miss_addr = {16'h0, 16'hFFFE};
      fill("top", 0, 16'hFFFE, 12, 13);
      extra_v = 1'b1;
      chk("idle_valid", 0, pk(0, 0, 0, 0, 0, 0, 2'b00));
      extra_v = 1'b0;

      // Short line, unit latency: penalty 4, DRAIN for one cycle.
      tick();
      miss2 = 2'b01;
      addr2 = {16'h0, 16'h0102};
      chk("short_t0", 1, pk(0, 0, 0, 0, 0, 0, 2'b01));
      tick();
      chk("short_t1", 1, pk(1, 16'h0100, 0, 0, 0, 0, 2'b01));
      tick();
      chk("short_t2", 1, pk(1, 16'h0102, 2'b01, 0, 16'h0100, 16'hB000, 2'b01));
      tick();
      chk("short_t3", 1, pk(0, 0, 2'b01, 2'b01, 16'h0102, 16'hB001, 2'b01));
      miss2 = 2'b00;
      tick();
      chk("short_t4", 1, pk(0, 0, 0, 0, 0, 0, 2'b00));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
